gcd_scheduler: RTL and testbench

- Shares one 16-bit subtractive GCD engine (start/a/b in, done/gcd out) between N requesters.
- Round-robin arbitration, operand capture, engine sequencing, per-requester result return.
- Sits between requester logic (e.g. debounced/one-pulsed pushbutton front ends) and the single engine instance.

---
 rtl/gcd_scheduler_if.sv | 24 ++
 rtl/gcd_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_gcd_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_scheduler_if.sv
// Requester-side bus of gcd_scheduler: request levels, packed operands,
// capture acknowledges and the shared one-hot-qualified response bus.
interface gcd_scheduler_if #(
    parameter int N = 4,
    parameter int W = 16
);
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_gcd;
    logic           rsp_err;

    modport master (
        output req, req_a, req_b,
        input  req_ack, rsp_valid, rsp_gcd, rsp_err
    );

    modport slave (
        input  req, req_a, req_b,
        output req_ack, rsp_valid, rsp_gcd, rsp_err
    );
endinterface

// File: rtl/gcd_scheduler.sv
// Round-robin scheduler sharing one subtractive GCD engine between N requesters.
// Optional engine watchdog enabled by defining GCD_SCHED_TIMEOUT_EN (limit = TIMEOUT cycles).
module gcd_scheduler #(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    gcd_scheduler_if.slave bus,
    output logic           busy,
    output logic           eng_start,
    output logic [W-1:0]   eng_a,
    output logic [W-1:0]   eng_b,
    input  logic           eng_done,
    input  logic [W-1:0]   eng_gcd
);
    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DRAIN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     req_ack_q, req_ack_d;
    logic [N-1:0]     rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_gcd_q, rsp_gcd_d;
    logic [W-1:0]     eng_a_q, eng_a_d;
    logic [W-1:0]     eng_b_q, eng_b_d;
    logic             busy_q, busy_d;
    logic             eng_start_q, eng_start_d;
    logic             timeout_hit;

    logic [W-1:0]     op_a [N];
    logic [W-1:0]     op_b [N];
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;

    if (N < 2 || N > 8 || W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("gcd_scheduler: parameter out of range");
    end

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
    assign timeout_hit = (state_q == S_BUSY) && !eng_done && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            op_a[i] = bus.req_a[i*W +: W];
            op_b[i] = bus.req_b[i*W +: W];
        end
    end

    // Rotating priority: scan ptr+1, ptr+2, ... wrapping modulo N.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % N);
            if (!grant_vld && bus.req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (grant_vld) state_d = S_ISSUE;
            S_ISSUE: state_d = S_BUSY;
            S_BUSY:  if (eng_done || timeout_hit) state_d = S_DRAIN;
            S_DRAIN: if (!eng_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        eng_a_d     = eng_a_q;
        eng_b_d     = eng_b_q;
        req_ack_d   = '0;
        rsp_valid_d = '0;
        rsp_gcd_d   = '0;
        eng_start_d = 1'b0;
        busy_d      = (state_d != S_IDLE);
`ifdef GCD_SCHED_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    ptr_d                = grant_idx;
                    idx_d                = grant_idx;
                    eng_a_d              = op_a[grant_idx];
                    eng_b_d              = op_b[grant_idx];
                    req_ack_d[grant_idx] = 1'b1;
                    eng_start_d          = 1'b1;
                end
            end
            S_ISSUE: begin
`ifdef GCD_SCHED_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            S_BUSY: begin
`ifdef GCD_SCHED_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (eng_done) begin
                    rsp_valid_d[idx_q] = 1'b1;
                    rsp_gcd_d          = eng_gcd;
                end else if (timeout_hit) begin
                    rsp_valid_d[idx_q] = 1'b1;
`ifdef GCD_SCHED_TIMEOUT_EN
                    rsp_err_d          = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking (<=) assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDX_W'(N - 1);
            idx_q       <= '0;
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            rsp_gcd_q   <= '0;
            eng_a_q     <= '0;
            eng_b_q     <= '0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_gcd_q   <= rsp_gcd_d;
            eng_a_q     <= eng_a_d;
            eng_b_q     <= eng_b_d;
            busy_q      <= busy_d;
            eng_start_q <= eng_start_d;
`ifdef GCD_SCHED_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.req_ack   = req_ack_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_gcd   = rsp_gcd_q;
`ifdef GCD_SCHED_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign busy          = busy_q;
    assign eng_start     = eng_start_q;
    assign eng_a         = eng_a_q;
    assign eng_b         = eng_b_q;
endmodule

// File: tb/tb_gcd_scheduler.sv
// Self-checking bench for gcd_scheduler: behavioural subtractive engine plus a
// response scoreboard filled from a Euclid reference as requests are driven.
module tb_gcd_scheduler;
    localparam int N       = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         busy, eng_start, eng_done;
    logic [W-1:0] eng_a, eng_b, eng_gcd;
    logic         eng_stall = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    typedef struct {
        int           idx;
        logic [W-1:0] gcd;
        logic         err;
    } exp_t;

    exp_t sb[$];

    gcd_scheduler_if #(.N(N), .W(W)) bus ();

    gcd_scheduler #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_done  (eng_done),
        .eng_gcd   (eng_gcd)
    );

    always #5 clk = ~clk;

    // Engine stand-in: subtract until equal or zero, then done for two cycles.
    logic [1:0]   e_st;
    logic [W-1:0] e_x, e_y;
    always @(posedge clk) begin
        if (rst) begin
            e_st <= 2'd0; eng_done <= 1'b0; eng_gcd <= '0; e_x <= '0; e_y <= '0;
        end else begin
            case (e_st)
                2'd0: begin
                    eng_done <= 1'b0;
                    if (eng_start) begin e_x <= eng_a; e_y <= eng_b; e_st <= 2'd1; end
                end
                2'd1: if (!eng_stall) begin
                    if (e_x == 0 || e_y == 0 || e_x == e_y) begin
                        eng_gcd <= (e_x == 0) ? e_y : e_x; eng_done <= 1'b1; e_st <= 2'd2;
                    end else if (e_x > e_y) e_x <= e_x - e_y;
                    else e_y <= e_y - e_x;
                end
                2'd2: e_st <= 2'd3;
                default: begin eng_done <= 1'b0; e_st <= 2'd0; end
            endcase
        end
    end

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every rsp_valid pulse.
    logic d1 = 1'b0, d2 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            d1 <= 1'b0; d2 <= 1'b0;
        end else begin
            if (bus.req_ack != '0 || bus.rsp_valid != '0)
                check("ack_rsp_exclusive", 32'(bus.req_ack != '0 && bus.rsp_valid != '0), 32'd0);
            if (bus.rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid_onehot", 32'(bus.rsp_valid), 32'(1) << e.idx);
                    check("rsp_gcd", 32'(bus.rsp_gcd), 32'(e.gcd));
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    if (!e.err) check("rsp_latency", 32'({d2, d1}), 32'b01);
                end
            end
            d2 <= d1;
            d1 <= eng_done;
        end
    end

    task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[idx*W +: W] = a;
        bus.req_b[idx*W +: W] = b;
        bus.req[idx]          = 1'b1;
        sb.push_back('{idx: idx, gcd: gcd_ref(a, b), err: 1'b0});
    endtask

    task automatic wait_ack(input string tag, input int idx, input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (bus.req_ack == '0 && n < budget);
        check(tag, 32'(bus.req_ack), 32'(1) << idx);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end
        while ((busy || sb.size() != 0) && n < budget);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_all_rsp"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({bus.req_ack, bus.rsp_valid, bus.rsp_err, busy, eng_start}), 32'd0);
        check({tag, "_rsp_gcd"}, 32'(bus.rsp_gcd), 32'd0);
        check({tag, "_eng_a"}, 32'(eng_a), 32'd0);
        check({tag, "_eng_b"}, 32'(eng_b), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acks;
        bus.req = '0; bus.req_a = '0; bus.req_b = '0;

        // Reset values
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Single request: ack exactly one cycle later, engine operands presented
        set_req(0, 16'd48, 16'd18);
        wait_ack("t1_ack_latency", 0, 1);
        check("t1_eng_start", 32'(eng_start), 32'd1);
        check("t1_eng_a", 32'(eng_a), 32'd48);
        check("t1_eng_b", 32'(eng_b), 32'd18);
        check("t1_busy", 32'(busy), 32'd1);
        bus.req = '0;
        wait_idle("t1", 2000);
        check("t1_done_low_at_idle", 32'(eng_done), 32'd0);

        // All four continuously: grants 0,1,2,3 from a fresh pointer
        do_reset();
        set_req(0, 16'd12, 16'd8);
        set_req(1, 16'd35, 16'd14);
        set_req(2, 16'd17, 16'd5);
        set_req(3, 16'd0,  16'd9);
        for (int g = 0; g < N; g++) begin
            wait_ack($sformatf("t2_ack%0d", g), g, 2000);
            bus.req[g] = 1'b0;
        end
        wait_idle("t2", 2000);

        // Round-robin: after granting 2, requests 0 and 2 -> 0 first, then 2
        set_req(2, 16'd100, 16'd75);
        wait_ack("t3_ack2_first", 2, 2000);
        bus.req[2] = 1'b0;
        set_req(0, 16'd81, 16'd27);
        set_req(2, 16'd91, 16'd35);
        wait_ack("t3_ack0", 0, 2000);
        bus.req[0] = 1'b0;
        wait_ack("t3_ack2_second", 2, 2000);
        bus.req[2] = 1'b0;
        wait_idle("t3", 2000);

        // Request raised during a long job waits for IDLE, acked one cycle after
        set_req(0, 16'd1000, 16'd3);
        wait_ack("t4_ack0", 0, 2000);
        bus.req[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_busy_mid_job", 32'(busy), 32'd1);
        set_req(1, 16'd21, 16'd14);
        n = 0; acks = 0;
        do begin
            @(negedge clk); n++;
            if (bus.req_ack != '0) acks++;
        end while (busy && n < 2000);
        check("t4_idle_reached", 32'(busy), 32'd0);
        check("t4_no_ack_while_busy", 32'(acks), 32'd0);
        @(negedge clk);
        check("t4_ack_idle_plus1", 32'(bus.req_ack), 32'b0010);
        bus.req[1] = 1'b0;
        wait_idle("t4", 2000);

        // Reset mid-job aborts it and restores the pointer
        bus.req_a[0 +: W] = 16'hFFFF;
        bus.req_b[0 +: W] = 16'd1;
        bus.req[0] = 1'b1;
        wait_ack("t5_ack0", 0, 2000);
        bus.req[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("t5_after_rst");
        rst = 1'b0;
        set_req(0, 16'd12, 16'd18);
        set_req(1, 16'd5,  16'd15);
        wait_ack("t5_ptr_reset_ack0", 0, 2000);
        bus.req[0] = 1'b0;
        wait_ack("t5_ack1", 1, 2000);
        bus.req[1] = 1'b0;
        wait_idle("t5", 2000);

        // Zero operands
        set_req(2, 16'd7, 16'd0);
        set_req(3, 16'd0, 16'd0);
        wait_ack("t6_ack2", 2, 2000);
        bus.req[2] = 1'b0;
        wait_ack("t6_ack3", 3, 2000);
        bus.req[3] = 1'b0;
        wait_idle("t6", 2000);

`ifdef GCD_SCHED_TIMEOUT_EN
        // Watchdog: stalled engine yields an error response after TIMEOUT busy cycles
        do_reset();
        eng_stall = 1'b1;
        bus.req_a[2*W +: W] = 16'd10;
        bus.req_b[2*W +: W] = 16'd4;
        bus.req[2] = 1'b1;
        sb.push_back('{idx: 2, gcd: '0, err: 1'b1});
        wait_ack("t7_ack2", 2, 2000);
        bus.req[2] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end
        while (bus.rsp_valid == '0 && n < 200);
        check("t7_timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
        wait_idle("t7", 200);
        eng_stall = 1'b0;
        do_reset();
`endif

        check("end_scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
